// File: rtl/matrix_mac_datapath.sv
// matrix_mac_datapath: multiply-accumulate datapath driven by the matrix
// multiplier's control FSM strobes. Computes one ENTRIES-long dot product per
// pass and presents it on a valid/ready result register.
// Optional feature macro: MAC_SATURATE_EN (clamp accumulator on carry out
// instead of wrapping).
module matrix_mac_datapath #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned ENTRIES    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_matrix,
  input  logic                  multiply_matrix,
  input  logic                  add,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  result_ready,
  output logic [3:0]            entry_count,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  output logic                  overflow,
  output logic                  overrun
);

  localparam int unsigned ProdWidth = 2 * DATA_WIDTH;
  localparam logic [3:0]  LastEntry = 4'(ENTRIES - 1);

  logic [3:0]           cnt_q, cnt_d;
  logic [ProdWidth-1:0] prod_q, prod_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_trk_q, ovf_trk_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic                 overrun_q, overrun_d;

  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic                 accumulate;

  // Entry counter: runs only while load_matrix is held, wraps after the last pair.
  always_comb begin
    cnt_d = 4'd0;
    if (load_matrix) begin
      cnt_d = (cnt_q == LastEntry) ? 4'd0 : cnt_q + 4'd1;
    end
  end

  // Product stage: full-width unsigned product captured during the multiply phase.
  always_comb begin
    prod_d = prod_q;
    if (multiply_matrix) begin
      prod_d = ProdWidth'(a_in) * ProdWidth'(b_in);
    end
  end

  // Accumulator: cleared on the first pair of a pass, otherwise adds the product
  // captured on the previous cycle (add drains the final one).
  always_comb begin
    sum        = {1'b0, acc_q} + (ACC_WIDTH + 1)'(prod_q);
    carry      = sum[ACC_WIDTH];
    accumulate = (multiply_matrix && (cnt_q != 4'd0)) || add;
    acc_d      = acc_q;
    ovf_trk_d  = ovf_trk_q;
    if (load_matrix && (cnt_q == 4'd0)) begin
      acc_d     = '0;
      ovf_trk_d = 1'b0;
    end else if (accumulate) begin
      ovf_trk_d = ovf_trk_q | carry;
`ifdef MAC_SATURATE_EN
      // Once clamped, stay clamped until the next pass clears the tracker.
      acc_d = (carry || ovf_trk_q) ? '1 : sum[ACC_WIDTH-1:0];
`else
      acc_d = sum[ACC_WIDTH-1:0];
`endif
    end
  end

  // Result register and valid/ready handshake; done wins over a same-cycle transfer.
  always_comb begin
    result_d  = result_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (done) begin
      result_d  = acc_q;
      ovf_d     = ovf_trk_q;
      valid_d   = 1'b1;
      overrun_d = valid_q && !result_ready;
    end else if (valid_q && result_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      prod_q    <= '0;
      acc_q     <= '0;
      ovf_trk_q <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      ovf_trk_q <= ovf_trk_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
    end
  end

  assign entry_count  = cnt_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign overflow     = ovf_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_matrix_mac_datapath.sv
// Directed self-checking bench for matrix_mac_datapath (default parameters).
module tb_matrix_mac_datapath;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_matrix, multiply_matrix, add, done;
  logic [7:0]  a_in, b_in;
  logic        result_ready;
  logic [3:0]  entry_count;
  logic [15:0] result;
  logic        result_valid, overflow, overrun;

  int n_cmp = 0;
  int n_err = 0;

  matrix_mac_datapath #(
    .DATA_WIDTH(8),
    .ACC_WIDTH (16),
    .ENTRIES   (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .load_matrix    (load_matrix),
    .multiply_matrix(multiply_matrix),
    .add            (add),
    .done           (done),
    .a_in           (a_in),
    .b_in           (b_in),
    .result_ready   (result_ready),
    .entry_count    (entry_count),
    .result         (result),
    .result_valid   (result_valid),
    .overflow       (overflow),
    .overrun        (overrun)
  );

  always #5 clock = ~clock;

  // Pass position c: 0..7 multiply, 8 add, 9 done, >=10 idle.
  task automatic drive(input int c, input logic [7:0] a, input logic [7:0] b, input logic rdy);
    load_matrix     = (c < 8);
    multiply_matrix = (c < 8);
    add             = (c == 8);
    done            = (c == 9);
    a_in            = a;
    b_in            = b;
    result_ready    = rdy;
  endtask

  task automatic test_reset();
    drive(10, 8'd0, 8'd0, 1'b0);
    reset = 1'b1;
    #3;
    n_cmp++;
    if ({entry_count, result, result_valid, overflow, overrun} !== 23'd0) begin
      n_err++;
      $display("FAIL reset_state: got cnt=%0d res=%0d v=%b o=%b r=%b want all 0",
               entry_count, result, result_valid, overflow, overrun);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (c < 8) begin
        n_cmp++;
        if (entry_count !== 4'(c)) begin
          n_err++;
          $display("FAIL basic_entry_count[%0d]: got %0d want %0d", c, entry_count, c);
        end
      end
      n_cmp++;
      if (result_valid !== 1'b0) begin
        n_err++;
        $display("FAIL basic_valid_early[%0d]: got %b want 0", c, result_valid);
      end
      drive(c, 8'(c + 1), 8'd1, 1'b1);
    end
    @(negedge clock);
    n_cmp++;
    if (result_valid !== 1'b1 || result !== 16'd36 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result: got v=%b res=%0d o=%b want v=1 res=36 o=0",
               result_valid, result, overflow);
    end
    drive(10, 8'd0, 8'd0, 1'b1);
    @(negedge clock);
    n_cmp++;
    if (result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_valid_drop: got %b want 0", result_valid);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_res;
`ifdef MAC_SATURATE_EN
    exp_res = 16'd65535;
`else
    exp_res = 16'd61448;
`endif
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      drive(c, 8'd255, 8'd255, 1'b1);
    end
    @(negedge clock);
    n_cmp++;
    if (result_valid !== 1'b1 || result !== exp_res || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_result: got v=%b res=%0d o=%b want v=1 res=%0d o=1",
               result_valid, result, overflow, exp_res);
    end
    drive(10, 8'd0, 8'd0, 1'b1);
    @(negedge clock);
  endtask

  task automatic test_overrun();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      drive(c, 8'd2, 8'd2, 1'b0);
    end
    // Second pass starts immediately while the first result is still pending.
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_cmp++;
      if (result_valid !== 1'b1 || result !== 16'd32 || overrun !== 1'b0) begin
        n_err++;
        $display("FAIL overrun_hold[%0d]: got v=%b res=%0d r=%b want v=1 res=32 r=0",
                 c, result_valid, result, overrun);
      end
      drive(c, 8'd3, 8'd3, 1'b0);
    end
    @(negedge clock);
    n_cmp++;
    if (overrun !== 1'b1 || result !== 16'd72 || result_valid !== 1'b1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_pulse: got r=%b res=%0d v=%b o=%b want r=1 res=72 v=1 o=0",
               overrun, result, result_valid, overflow);
    end
    drive(10, 8'd0, 8'd0, 1'b0);
    @(negedge clock);
    n_cmp++;
    if (overrun !== 1'b0 || result_valid !== 1'b1 || result !== 16'd72) begin
      n_err++;
      $display("FAIL overrun_single: got r=%b v=%b res=%0d want r=0 v=1 res=72",
               overrun, result_valid, result);
    end
    drive(10, 8'd0, 8'd0, 1'b1);
    @(negedge clock);
    n_cmp++;
    if (result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_accept: got v=%b want 0", result_valid);
    end
    drive(10, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      drive(c, 8'd1, 8'd1, 1'b0);
    end
    // Pending result 8; the next done coincides with acceptance.
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_cmp++;
      if (result_valid !== 1'b1 || result !== 16'd8) begin
        n_err++;
        $display("FAIL b2b_pending[%0d]: got v=%b res=%0d want v=1 res=8", c, result_valid, result);
      end
      drive(c, 8'd2, 8'd3, (c == 9));
    end
    @(negedge clock);
    n_cmp++;
    if (result_valid !== 1'b1 || result !== 16'd48 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_coincident: got v=%b res=%0d r=%b want v=1 res=48 r=0",
               result_valid, result, overrun);
    end
    drive(10, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic test_midpass_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c == 4) begin
        n_cmp++;
        if (entry_count !== 4'd4) begin
          n_err++;
          $display("FAIL midreset_count: got %0d want 4", entry_count);
        end
      end
      drive(c, 8'd9, 8'd9, 1'b0);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({entry_count, result, result_valid, overflow, overrun} !== 23'd0) begin
      n_err++;
      $display("FAIL midreset_async: got cnt=%0d res=%0d v=%b o=%b r=%b want all 0",
               entry_count, result, result_valid, overflow, overrun);
    end
    @(negedge clock);
    drive(10, 8'd0, 8'd0, 1'b1);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_cmp++;
      if (result_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_no_valid[%0d]: got %b want 0", c, result_valid);
      end
      drive(c, 8'd1, 8'd1, 1'b1);
    end
    @(negedge clock);
    n_cmp++;
    if (result_valid !== 1'b1 || result !== 16'd8 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_pass: got v=%b res=%0d o=%b want v=1 res=8 o=0",
               result_valid, result, overflow);
    end
    drive(10, 8'd0, 8'd0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_overrun();
    test_back_to_back();
    test_midpass_reset();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_mac_datapath.md
# matrix_mac_datapath

Arithmetic datapath driven by the matrix multiplier's control FSM. It consumes the FSM's `load_matrix`, `multiply_matrix`, `add` and `done` strobes, and produces the `entry_count` the FSM uses to leave its multiply phase. Each pass computes one dot product of `ENTRIES` operand pairs. The block presents that result on a valid/ready output register for the downstream result store.

## Interface
- `DATA_WIDTH`, 8: width of each unsigned operand.
- `ACC_WIDTH`, 16: width of the accumulator and of `result`. Must be ≥ 2·`DATA_WIDTH`.
- `ENTRIES`, 8: operand pairs per dot product. Legal range 2..16. The controller's exit compare of 7 corresponds to the default.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `load_matrix` in 1: FSM multiply-phase strobe; enables the entry counter.
- `multiply_matrix` in 1: FSM multiply-phase strobe; enables product capture.
- `add` in 1: FSM accumulate strobe; drains the final product.
- `done` in 1: FSM store strobe; latches the result.
- `a_in` in DATA_WIDTH: row operand, sampled while `multiply_matrix`=1.
- `b_in` in DATA_WIDTH: column operand, sampled while `multiply_matrix`=1.
- `result_ready` in 1: downstream accepts `result`.
- `entry_count` out 4: index of the operand pair sampled this cycle; feeds the FSM.
- `result` out ACC_WIDTH: registered dot product.
- `result_valid` out 1: `result` holds an unaccepted value.
- `overflow` out 1: the accumulation for the current `result` exceeded ACC_WIDTH.
- `overrun` out 1: one-cycle pulse when an unaccepted result is overwritten.

## Operation
- **Entry counter**
  - Cleared to 0 whenever `load_matrix`=0.
  - While `load_matrix`=1: increments each cycle 0..ENTRIES-1, then wraps to 0.
  - `entry_count` is a direct register output.
- **Product stage**
  - When `multiply_matrix`=1: `prod` ← `a_in`·`b_in`, full 2·DATA_WIDTH bits, unsigned.
- **Accumulator**
  - If `load_matrix`=1 and `entry_count`=0: `acc` ← 0 and the overflow tracker ← 0.
  - Else if (`multiply_matrix`=1 and `entry_count`≠0) or `add`=1: `acc` ← `acc` + `prod`, zero-extended.
  - A carry out of ACC_WIDTH sets the overflow tracker; the tracker is sticky until the next clear.
- **Result register**
  - On `done`=1: `result` ← `acc`, `overflow` ← tracker, `result_valid` ← 1.
  - If `result_valid`=1 and `result_ready`=0 in that same cycle, `overrun` pulses 1 for one cycle.
- **Handshake**
  - Transfer occurs on `result_valid`=1 and `result_ready`=1; `result_valid` then clears next cycle.
  - `done` and a transfer in the same cycle: the new value loads, `result_valid` stays 1, no `overrun`.
  - `result` and `overflow` hold stable while `result_valid`=1 and not accepted.
- **Input protocol**
  - Strobes are used as given; there is no internal state machine.
  - `add` outside the accumulate phase adds the stale `prod`. This is the controller's responsibility and is not trapped.
- **Reset**
  - Counter, `prod`, `acc` and tracker ← 0.
  - `result` ← 0, `result_valid` ← 0, `overflow` ← 0, `overrun` ← 0.
  - A reset mid-pass discards the partial sum. No valid result is produced until a full new pass completes.

## Timing
- Pass timeline with ENTRIES=8:
  - Cycles 0..7 (multiply phase): pairs 0..7 sampled; `entry_count` shows 0..7.
  - Cycles 1..7: products 0..6 accumulated.
  - Cycle 8 (`add`=1): product 7 accumulated.
  - Cycle 9 (`done`=1): `result` latched.
  - Cycle 10: `result_valid`=1.
- Latency from the last operand sample to `result_valid`: 3 cycles.
- `entry_count` reads ENTRIES-1 during the final multiply cycle, so the FSM's combinational compare exits exactly after ENTRIES samples.
- Throughput: one result per ENTRIES+2 cycles plus the FSM idle cycle; back-to-back passes are supported.

## Configuration
- `MAC_SATURATE_EN` defined:
  - On carry out, `acc` clamps to 2^ACC_WIDTH−1 and stays clamped for the rest of the pass.
  - `overflow` is reported.
- `MAC_SATURATE_EN` undefined:
  - `acc` wraps modulo 2^ACC_WIDTH.
  - `overflow` is still reported.

## Test plan
- `a_in`=1..8, `b_in`=1, defaults, `result_ready`=1 → `entry_count` runs 0..7; `result`=36 and `result_valid`=1 in cycle 10; `overflow`=0.
- `a_in`=`b_in`=255 ×8:
  - Without macro: `result`=61448, `overflow`=1.
  - With `MAC_SATURATE_EN`: `result`=65535, `overflow`=1.
- `result_ready`=0, two passes (first `a_in`=`b_in`=2 → 32, then 3 → 72):
  - `result` holds 32 until the second `done`.
  - `overrun` pulses once, `result` becomes 72, `valid` stays 1.
  - `result_ready`=1 → `valid` drops next cycle.
- `done` coincident with `result_ready`=1 on a pending result → new value loaded, `valid` continuous, `overrun`=0.
- `reset` asserted asynchronously at `entry_count`=4 mid-pass → all outputs 0 immediately. A following full pass with `a_in`=`b_in`=1 yields 8.
